// File: rtl/fifo_unpacker.sv
// fifo_unpacker: pops PAR_READ-wide groups from a FIFO read port and
// serializes them one word per transfer onto a valid/ready stream.
// The next group is popped on the final transfer of the current one,
// so back-to-back groups stream with no bubble cycles.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | nothing held; pop a group when drain_en && !fifo_empty
// SEND  | presenting hold[idx]; advance on each out_ready transfer
module fifo_unpacker #(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_READ   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data [0:PAR_READ-1],
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic                  drain_en,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int IDX_W = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_READ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [DATA_WIDTH-1:0] hold [0:PAR_READ-1];
    logic                  load;
    logic                  xfer;
    logic                  can_pop;

    // Next-state, pop request and stream handshake; rst masks every output
    // so nothing is popped or presented while reset is held.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        load      = 1'b0;
        xfer      = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        can_pop   = drain_en && !fifo_empty;
        case (state)
            IDLE: begin
                if (can_pop) begin
                    load      = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                xfer      = out_ready;
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        idx_nxt = '0;
                        if (can_pop) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            load      = 1'b0;
            xfer      = 1'b0;
            out_valid = 1'b0;
            busy      = 1'b0;
        end
    end

    assign fifo_read_enable = load;

    // Output word comes only from the hold register, never from fifo_data.
    assign out_data = out_valid ? hold[idx] : '0;

    // State, index, hold register and delivered-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            word_count <= '0;
            for (int i = 0; i < PAR_READ; i++) begin
                hold[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (load) begin
                for (int i = 0; i < PAR_READ; i++) begin
                    hold[i] <= fifo_data[i];
                end
            end
            if (xfer) begin
                word_count <= word_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/fifo_unpacker.md
FIFO_UNPACKER -- requirements
Module: fifo_unpacker

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of one data word.
REQ-002 Parameter PAR_READ, default 4: words delivered per FIFO read (matches the FIFO read port width); must be at least 1.
REQ-003 Parameter CNT_WIDTH, default 16: width of the delivered-word counter.
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port fifo_data, input, unpacked array [0:PAR_READ-1] of DATA_WIDTH: combinational FIFO read port; element 0 is the oldest word.
REQ-007 Port fifo_empty, input, 1: high when the FIFO cannot supply PAR_READ words.
REQ-008 Port fifo_read_enable, output, 1: one-cycle pop request; the FIFO advances its read pointer by PAR_READ at the next edge.
REQ-009 Port drain_en, input, 1: enables new FIFO pops; it does not stop words already held.
REQ-010 Port out_data, output, DATA_WIDTH: serialized word stream.
REQ-011 Port out_valid, output, 1: out_data is valid.
REQ-012 Port out_ready, input, 1: downstream accepts the word.
REQ-013 Port busy, output, 1: a held group is not fully delivered.
REQ-014 Port word_count, output, CNT_WIDTH: total words accepted downstream since reset.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and SEND.
REQ-016 IDLE: fifo_read_enable SHALL be combinationally high when drain_en && !fifo_empty.
- On that cycle, fifo_data[0..PAR_READ-1] is captured into the hold register.
- idx goes to 0 and the state goes to SEND.
REQ-017 SEND: out_valid SHALL be 1, and out_data SHALL be hold[idx], driven from registers with no combinational path from fifo_data.
REQ-018 A transfer is out_valid && out_ready; on a transfer with idx < PAR_READ-1, idx SHALL increment by 1.
REQ-019 On a transfer with idx == PAR_READ-1 and drain_en && !fifo_empty:
- fifo_read_enable SHALL be high in that same cycle.
- The hold register reloads and idx goes to 0, staying in SEND (back-to-back groups, zero bubble cycles).
REQ-020 On a transfer with idx == PAR_READ-1 without a refill condition, the state SHALL return to IDLE.
REQ-021 Without a transfer, hold, idx and out_data SHALL remain stable while out_valid stays high (standard valid/ready: valid is never withdrawn).
REQ-022 fifo_read_enable SHALL never be high in SEND except in the REQ-019 cycle, and never high when fifo_empty is high.
REQ-023 busy SHALL equal (state == SEND).
REQ-024 word_count SHALL increment by 1 per transfer and wrap modulo 2^CNT_WIDTH.
REQ-025 idx width SHALL be max(1, $clog2(PAR_READ)).
REQ-026 With PAR_READ = 1, every transfer SHALL either refill or return to IDLE.
REQ-027 Deasserting drain_en mid-group SHALL let the current group finish, then the FSM SHALL stop in IDLE.

Reset
REQ-028 While rst is high at a clock edge, the block SHALL enter IDLE with idx = 0, hold = 0, word_count = 0.
REQ-029 During and after reset: out_valid = 0, out_data = 0, busy = 0, fifo_read_enable = 0 (gated by rst).
REQ-030 A reset asserted mid-group SHALL discard the remaining held words without issuing any pop.

Verification (DATA_WIDTH = 8, PAR_READ = 4)
REQ-031 Single group: FIFO holds {0x11,0x22,0x33,0x44}, out_ready = 1, drain_en = 1.
- Required: one fifo_read_enable pulse.
- out_data 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles starting 1 cycle after the pop.
- Then back to IDLE; word_count = 4.
REQ-032 Back-to-back: fifo_empty stays low for 3 groups, out_ready = 1.
- Required: 12 consecutive valid cycles with no gap.
- fifo_read_enable pulses exactly 3 times, the 2nd and 3rd coinciding with idx == 3 transfers.
REQ-033 Backpressure: out_ready = 0 for 5 cycles at idx = 2.
- Required: out_valid = 1 and out_data = 0x33 held for all 5 cycles.
- No fifo_read_enable; delivery resumes with 0x44.
REQ-034 Empty/disable:
- fifo_empty = 1 with drain_en = 1 → no pop, out_valid = 0.
- drain_en = 0 with data present → no pop.
- drain_en dropped at idx = 1 → group completes and no further pop.
REQ-035 Reset mid-group: rst = 1 at idx = 2 → next cycle out_valid = 0, word_count = 0, and no pop during rst.
REQ-036 Counter wrap: with CNT_WIDTH = 4, after 16 transfers word_count = 0, and after 17 transfers it equals 1.
